pp_align_accumulate: RTL and testbench
======================================

Name: pp_align_accumulate

Overview:
- Middle/back stage of the SD4 MAC datapath.
- Takes nine 5-bit signed partial products and their 5-bit exponents, plus the group maximum exponent.
- Right-aligns each product to the maximum exponent in a 16-bit fixed-point frame, registers the nine aligned values, then sums them in a combinational 9-input adder tree into a 20-bit two's-complement result for normalization.

Parameters:
- N_PP, 9, number of partial products (fixed; the tree is sized for 9).
- PP_W, 5, signed partial-product width.
- EXP_W, 5, unsigned exponent width.
- ALIGN_W, 16, aligned partial-product width.
- SUM_W, 20, adder-tree output width (ALIGN_W + ceil(log2(N_PP))).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- pp_in  input  45  packed signed partial products; pp_0 = [44:40] ... pp_8 = [4:0].
- exp_in  input  45  packed exponents; exp_0 = [44:40] ... exp_8 = [4:0].
- exp_max_in  input  5  maximum of the nine exponents, from the upstream max_exponent block.
- signed_sum  output  20  two's-complement sum of the aligned products.
- exp_max_out  output  5  exp_max_in, delayed to match signed_sum.

Behaviour:
- Alignment (combinational, per lane i):
  - d_i = exp_max_in - exp_i, unsigned 5-bit.
  - If exp_i > exp_max_in, force d_i = 0 (protection only; not a legal input).
  - aligned_i = arithmetic right shift of {pp_i, 11'b0} (16 bits) by d_i.
  - For d_i >= 16: result is all sign bits (0x0000 for pp >= 0, 0xFFFF for pp < 0).
  - Bits shifted out are truncated. No rounding or sticky bit.
- Align register stage:
  - Nine 16-bit registers capture aligned_0..8 every clock.
  - A 5-bit register captures exp_max_in every clock.
  - No enable.
- Adder tree (combinational, from the registered aligned values):
  - Sign-extend each operand to 20 bits and add all nine.
  - Structure is four pairwise adds, then two, then one, then a final add of the ninth operand.
  - Overflow is impossible: 9 * (-32768) = -294912 fits in 20-bit signed.
- Latency:
  - 1 cycle from inputs to signed_sum and exp_max_out, which change after the edge that samples the inputs.
  - Full throughput: one new vector accepted per cycle.
- Reset:
  - While rst = 1, all aligned registers and the exp_max register are 0 asynchronously.
  - Consequently signed_sum = 0 and exp_max_out = 0.
  - Assertion mid-stream discards in-flight data immediately, without waiting for a clock edge.
  - After deassertion, the first valid output appears one cycle after the first sampled input.
- No handshake and no valid signal; the upstream pipeline is free-running.

Optional Feature:
- Macro: PP_ALIGN_OUT_REG_EN
- Defined:
  - signed_sum and exp_max_out are additionally registered, giving 2-cycle latency.
  - The output registers are also cleared asynchronously by rst.
- Undefined:
  - The adder-tree output drives signed_sum directly, giving 1-cycle latency.
- The test plan values below are unchanged either way; only the latency differs.

Test Plan:
- Reset: hold rst = 1 with nonzero inputs -> signed_sum = 0x00000 and exp_max_out = 0 throughout, with no clock edge required.
- All lanes pp = 5'b01111 (+15), all exp = exp_max_in = 10 -> each aligned value is 0x7800; signed_sum = 0x43800 (276480), exp_max_out = 10 after the defined latency.
- pp_0 = 5'b10000 (-16), exp_0 = exp_max_in = 7, other lanes pp = 0 -> aligned_0 = 0x8000; signed_sum = 0xF8000 (-32768).
- Shift: pp_0 = 5'b01000 (+8), exp_0 = 3, exp_max_in = 5, others 0 -> d = 2, aligned_0 = 0x1000; signed_sum = 0x01000. Then pp_0 = 5'b11111, exp_0 = 0, exp_max_in = 20 -> signed_sum = 0xFFFFF (-1). With pp_0 = 5'b00001 under the same exponents -> signed_sum = 0.
- Back-to-back vectors on consecutive cycles (the +15 case, then the -16 case) -> outputs 0x43800 then 0xF8000 on consecutive cycles, with no bubble.
- Reset mid-stream: assert rst asynchronously between edges while 0x43800 is output -> signed_sum drops to 0 at once. Release rst and apply the shift case -> 0x01000 after the defined latency.

Source files
------------

// File: rtl/pp_align_accumulate.sv
// Aligns nine signed partial products to the group max exponent, registers them,
// and sums them in a 9-input adder tree. Optional output stage: PP_ALIGN_OUT_REG_EN.
module pp_align_accumulate (
  input  logic        clk,
  input  logic        rst,
  input  logic [44:0] pp_in,
  input  logic [44:0] exp_in,
  input  logic [4:0]  exp_max_in,
  output logic [19:0] signed_sum,
  output logic [4:0]  exp_max_out
);

  localparam int unsigned N_PP    = 9;
  localparam int unsigned PP_W    = 5;
  localparam int unsigned EXP_W   = 5;
  localparam int unsigned ALIGN_W = 16;
  localparam int unsigned SUM_W   = 20;
  localparam int unsigned PAD_W   = ALIGN_W - PP_W;
  localparam int unsigned EXT_W   = SUM_W - ALIGN_W;

  logic [ALIGN_W-1:0] aligned_d [N_PP];
  logic [ALIGN_W-1:0] aligned_q [N_PP];
  logic [EXP_W-1:0]   exp_max_q;

  // Per-lane right alignment; lane 0 sits in the most significant slice
  for (genvar g = 0; g < N_PP; g++) begin : g_lane
    logic [PP_W-1:0]           pp_lane;
    logic [EXP_W-1:0]          exp_lane;
    logic [EXP_W-1:0]          shift;
    logic signed [ALIGN_W-1:0] frame;

    assign pp_lane  = pp_in[PP_W*(N_PP-1-g) +: PP_W];
    assign exp_lane = exp_in[EXP_W*(N_PP-1-g) +: EXP_W];
    // An exponent above the max is not legal; treat it as already aligned
    assign shift    = (exp_lane > exp_max_in) ? '0 : EXP_W'(exp_max_in - exp_lane);
    assign frame    = {pp_lane, {PAD_W{1'b0}}};
    assign aligned_d[g] = (shift >= EXP_W'(ALIGN_W)) ? {ALIGN_W{pp_lane[PP_W-1]}}
                                                     : ALIGN_W'(frame >>> shift);
  end

  // Align stage registers, free-running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_PP; i++) aligned_q[i] <= '0;
      exp_max_q <= '0;
    end else begin
      for (int i = 0; i < N_PP; i++) aligned_q[i] <= aligned_d[i];
      exp_max_q <= exp_max_in;
    end
  end

  logic [SUM_W-1:0] ext [N_PP];
  logic [SUM_W-1:0] lvl1 [4];
  logic [SUM_W-1:0] lvl2 [2];
  logic [SUM_W-1:0] lvl3;
  logic [SUM_W-1:0] tree_sum;

  for (genvar g = 0; g < N_PP; g++) begin : g_ext
    assign ext[g] = {{EXT_W{aligned_q[g][ALIGN_W-1]}}, aligned_q[g]};
  end

  // Four pairwise adds, then two, then one, then the ninth operand
  for (genvar g = 0; g < 4; g++) begin : g_lvl1
    assign lvl1[g] = ext[2*g] + ext[2*g+1];
  end
  assign lvl2[0]  = lvl1[0] + lvl1[1];
  assign lvl2[1]  = lvl1[2] + lvl1[3];
  assign lvl3     = lvl2[0] + lvl2[1];
  assign tree_sum = lvl3 + ext[N_PP-1];

`ifdef PP_ALIGN_OUT_REG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signed_sum  <= '0;
      exp_max_out <= '0;
    end else begin
      signed_sum  <= tree_sum;
      exp_max_out <= exp_max_q;
    end
  end
`else
  assign signed_sum  = tree_sum;
  assign exp_max_out = exp_max_q;
`endif

endmodule

// File: tb/tb_pp_align_accumulate.sv
// Self-checking bench for pp_align_accumulate: directed table, hand sequences and
// random streaming against an arithmetic reference model.
module tb_pp_align_accumulate;

`ifdef PP_ALIGN_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [44:0] pp_in = '0;
  logic [44:0] exp_in = '0;
  logic [4:0]  exp_max_in = '0;
  logic [19:0] signed_sum;
  logic [4:0]  exp_max_out;

  int total = 0;
  int bad   = 0;

  pp_align_accumulate dut (
    .clk(clk), .rst(rst), .pp_in(pp_in), .exp_in(exp_in),
    .exp_max_in(exp_max_in), .signed_sum(signed_sum), .exp_max_out(exp_max_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [44:0] pp;
    logic [44:0] ex;
    logic [4:0]  emax;
    logic [19:0] want_sum;
    string       name;
  } tv_t;

  typedef struct {
    logic [44:0] pp;
    logic [44:0] ex;
    logic [4:0]  emax;
  } vec_t;

  vec_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  // Lane 0 gets its own values; lanes 1..8 share the others
  function automatic vec_t mk(input logic [4:0] p0, input logic [4:0] e0,
                              input logic [4:0] po, input logic [4:0] eo,
                              input logic [4:0] emax);
    vec_t v;
    v.pp = {p0, {8{po}}};
    v.ex = {e0, {8{eo}}};
    v.emax = emax;
    return v;
  endfunction

  // Reference: each product is pp * 2^11 / 2^d rounded toward minus infinity
  function automatic logic [19:0] model_sum(input vec_t v);
    longint acc = 0;
    for (int i = 0; i < 9; i++) begin
      logic [4:0] pb;
      logic [4:0] eb;
      longint val, div, quo;
      int d;
      pb = v.pp[5*(8-i) +: 5];
      eb = v.ex[5*(8-i) +: 5];
      d = (eb > v.emax) ? 0 : int'(v.emax) - int'(eb);
      val = longint'($signed(pb)) * 2048;
      div = longint'(1) << d;
      if (val >= 0) quo = val / div;
      else          quo = -((-val + div - 1) / div);
      acc += quo;
    end
    return 20'(acc);
  endfunction

  task automatic drive(input vec_t v);
    pp_in = v.pp;
    exp_in = v.ex;
    exp_max_in = v.emax;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Streaming: compare the vector that entered LAT edges ago
  task automatic push_and_step(input vec_t v, input string name);
    vec_t old;
    drive(v);
    q.push_back(v);
    step();
    if (q.size() == LAT) begin
      old = q.pop_front();
      check({name, " sum"}, 32'(signed_sum), 32'(model_sum(old)));
      check({name, " emax"}, 32'(exp_max_out), 32'(old.emax));
    end
  endtask

  task automatic flush(input string name);
    for (int i = 0; i < LAT - 1; i++) push_and_step(mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0), name);
    q.delete();
  endtask

  tv_t  tbl[8];
  vec_t v_pos, v_neg, v_shift, v;

  initial begin
    v_pos   = mk(5'b01111, 5'd10, 5'b01111, 5'd10, 5'd10);
    v_neg   = mk(5'b10000, 5'd7,  5'b00000, 5'd7,  5'd7);
    v_shift = mk(5'b01000, 5'd3,  5'b00000, 5'd0,  5'd5);

    tbl[0] = '{v_pos.pp, v_pos.ex, v_pos.emax, 20'h43800, "all_plus15"};
    tbl[1] = '{v_neg.pp, v_neg.ex, v_neg.emax, 20'hF8000, "minus16"};
    tbl[2] = '{v_shift.pp, v_shift.ex, v_shift.emax, 20'h01000, "shift_d2"};
    v = mk(5'b11111, 5'd0, 5'd0, 5'd0, 5'd20);
    tbl[3] = '{v.pp, v.ex, v.emax, 20'hFFFFF, "neg_d20"};
    v = mk(5'b00001, 5'd0, 5'd0, 5'd0, 5'd20);
    tbl[4] = '{v.pp, v.ex, v.emax, 20'h00000, "pos_d20"};
    v = mk(5'b10000, 5'd0, 5'd0, 5'd0, 5'd16);
    tbl[5] = '{v.pp, v.ex, v.emax, 20'hFFFFF, "neg_d16"};
    v = mk(5'b01111, 5'd0, 5'd0, 5'd0, 5'd31);
    tbl[6] = '{v.pp, v.ex, v.emax, 20'h00000, "pos_d31"};
    v = mk(5'b00001, 5'd9, 5'd0, 5'd0, 5'd4);
    tbl[7] = '{v.pp, v.ex, v.emax, 20'h00800, "exp_above_max"};

    // Reset with nonzero inputs, before any clock edge and across a few
    drive(v_pos);
    #1;
    check("reset_sum_noclk", 32'(signed_sum), 32'h0);
    check("reset_emax_noclk", 32'(exp_max_out), 32'h0);
    step(); step();
    check("reset_sum_held", 32'(signed_sum), 32'h0);
    check("reset_emax_held", 32'(exp_max_out), 32'h0);
    rst = 1'b0;

    // Directed table
    foreach (tbl[i]) begin
      pp_in = tbl[i].pp;
      exp_in = tbl[i].ex;
      exp_max_in = tbl[i].emax;
      repeat (LAT) step();
      check({tbl[i].name, " sum"}, 32'(signed_sum), 32'(tbl[i].want_sum));
      check({tbl[i].name, " emax"}, 32'(exp_max_out), 32'(tbl[i].emax));
    end

    // Back-to-back without bubble
    q.delete();
    push_and_step(v_pos, "b2b_pos");
    push_and_step(v_neg, "b2b_neg");
    push_and_step(v_shift, "b2b_shift");
    flush("b2b_flush");

    // Asynchronous reset between edges while 0x43800 is on the output
    drive(v_pos);
    repeat (LAT) step();
    check("pre_reset_sum", 32'(signed_sum), 32'h43800);
    #2 rst = 1'b1;
    #1;
    check("async_reset_sum", 32'(signed_sum), 32'h0);
    check("async_reset_emax", 32'(exp_max_out), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(v_shift);
    repeat (LAT) step();
    check("post_reset_sum", 32'(signed_sum), 32'h01000);
    check("post_reset_emax", 32'(exp_max_out), 32'd5);

    // Random streaming against the model
    q.delete();
    for (int n = 0; n < 300; n++) begin
      vec_t r;
      r.emax = 5'($urandom_range(0, 31));
      for (int i = 0; i < 9; i++) begin
        r.pp[5*i +: 5] = 5'($urandom);
        if ($urandom_range(0, 15) == 0) r.ex[5*i +: 5] = 5'($urandom);
        else                            r.ex[5*i +: 5] = 5'($urandom_range(0, int'(r.emax)));
      end
      push_and_step(r, "random");
    end
    flush("random_flush");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
